// File: rtl/spi_fb_stream_if.sv
// Word-stream and framebuffer-read bus of spi_fb_stream.
// master = the stream source, slave = the consumer / framebuffer RAM side.
interface spi_fb_stream_if #(
  parameter int AW = 10
);
  logic          start;
  logic          busy;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data;
  logic          get;
  logic          dc;
  logic [7:0]    data;
  logic          empty;

  modport master (
    input  start, fb_data, get,
    output busy, fb_addr, dc, data, empty
  );

  modport slave (
    output start, fb_data, get,
    input  busy, fb_addr, dc, data, empty
  );
endinterface

// File: rtl/spi_fb_stream.sv
// Word source for spi_display: one init command list after reset, then on each start an
// address-window preamble plus a full framebuffer dump from a synchronous RAM.
module spi_fb_stream #(
  parameter int W        = 128,
  parameter int PAGES    = 8,
  parameter int INIT_LEN = 20,
  parameter logic [0:31][7:0] INIT_ROM = {
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
    8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
    8'h81, 8'hCF, 8'hA6, 8'hAF, {12{8'h00}}
  }
) (
  input logic             clock,
  input logic             reset,
  spi_fb_stream_if.master bus
);

  localparam int FRAME = W * PAGES;
  localparam int AW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME - 1);
  localparam logic [5:0] INIT_CNT = 6'(INIT_LEN);
  localparam logic [7:0] COL_END  = 8'(W - 1);
  localparam logic [7:0] PAGE_END = 8'(PAGES - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_ADDR, S_PIX} state_t;
  localparam state_t RESET_STATE = (INIT_LEN > 0) ? S_INIT : S_IDLE;

  state_t        state;
  state_t        state_next;
  logic          valid;
  logic          dc_q;
  logic [7:0]    data_q;
  logic [5:0]    idx;
  logic [AW-1:0] fb_addr_q;
  logic          pending;
  logic          last_pix;
  logic          pop;
  logic          busy;

  function automatic logic [7:0] addr_word(input logic [5:0] i);
    case (i)
      6'd0:    return 8'h21;
      6'd1:    return 8'h00;
      6'd2:    return COL_END;
      6'd3:    return 8'h22;
      6'd4:    return 8'h00;
      default: return PAGE_END;
    endcase
  endfunction

  assign pop = valid & bus.get;

  always_ff @(posedge clock) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_INIT:  if (pop && idx == INIT_CNT) state_next = S_IDLE;
      S_IDLE:  if (bus.start)              state_next = S_ADDR;
      S_ADDR:  if (pop && idx == 6'd6)     state_next = S_PIX;
      S_PIX:   if (pop && last_pix)        state_next = S_IDLE;
      default:                             state_next = RESET_STATE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
  end

  // idx counts words already loaded in INIT/ADDR; in PIX the next address is prefetched
  // into fb_addr_q at capture time so the RAM sees it on the edge that pops the current word.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid     <= 1'b0;
      dc_q      <= 1'b0;
      data_q    <= 8'h00;
      idx       <= 6'd0;
      fb_addr_q <= '0;
      pending   <= 1'b0;
      last_pix  <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          if ((!valid || pop) && idx < INIT_CNT) begin
            valid  <= 1'b1;
            dc_q   <= 1'b0;
            data_q <= INIT_ROM[idx[4:0]];
            idx    <= idx + 6'd1;
          end else if (pop) begin
            valid <= 1'b0;
            idx   <= 6'd0;
          end
        end
        S_IDLE: begin
          if (bus.start) begin
            valid  <= 1'b1;
            dc_q   <= 1'b0;
            data_q <= 8'h21;
            idx    <= 6'd1;
          end
        end
        S_ADDR: begin
          if (pop) begin
            if (idx < 6'd6) begin
              data_q <= addr_word(idx);
              idx    <= idx + 6'd1;
            end else begin
              valid   <= 1'b0;
              idx     <= 6'd0;
              pending <= 1'b1;
            end
          end
        end
        S_PIX: begin
          if (pending) begin
            valid     <= 1'b1;
            dc_q      <= 1'b1;
            data_q    <= bus.fb_data;
            pending   <= 1'b0;
            last_pix  <= (fb_addr_q == LAST_ADDR);
            fb_addr_q <= (fb_addr_q == LAST_ADDR) ? '0 : fb_addr_q + AW'(1);
          end else if (pop) begin
            valid   <= 1'b0;
            pending <= !last_pix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.empty   = ~valid;
  assign bus.dc      = dc_q;
  assign bus.data    = data_q;
  assign bus.fb_addr = fb_addr_q;

endmodule

// File: tb/tb_spi_fb_stream.sv
// Scoreboard bench for spi_fb_stream: a full-size instance with an init list and a
// 4x2 instance without one; every popped word is matched against the expected queue.
module tb_spi_fb_stream;

  typedef struct {
    logic       dc;
    logic [7:0] data;
    int         addr;
  } word_t;

  logic clock  = 1'b0;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  always #5 clock = ~clock;

  spi_fb_stream_if #(.AW(10)) bus0 ();
  spi_fb_stream_if #(.AW(3))  bus1 ();

  spi_fb_stream #(.W(128), .PAGES(8), .INIT_LEN(20)) dut0 (
    .clock(clock), .reset(reset0), .bus(bus0.master)
  );
  spi_fb_stream #(.W(4), .PAGES(2), .INIT_LEN(0)) dut1 (
    .clock(clock), .reset(reset1), .bus(bus1.master)
  );

  logic [7:0] init_cmds [20] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
    8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hA6, 8'hAF
  };

  // Synchronous framebuffer RAMs: data appears one edge after the address.
  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [8];
  always @(posedge clock) begin
    bus0.fb_data <= mem0[bus0.fb_addr];
    bus1.fb_data <= mem1[bus1.fb_addr];
  end

  word_t      q[$];
  int         checks = 0;
  int         errors = 0;
  logic       exp_busy = 1'b1;
  logic       exp_empty = 1'b1;
  logic       have_exp = 1'b0;
  logic       prev_rst = 1'b0;
  logic       hold = 1'b0;
  logic       held_dc = 1'b0;
  logic [7:0] held_data = 8'h00;
  int         pix_popped = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int initLen(input int d);
    return (d == 0) ? 20 : 0;
  endfunction

  function automatic int frameLen(input int d);
    return (d == 0) ? 1024 : 8;
  endfunction

  task automatic pushInit(input int d);
    word_t w;
    for (int i = 0; i < initLen(d); i++) begin
      w.dc = 1'b0; w.data = init_cmds[i]; w.addr = -1;
      q.push_back(w);
    end
  endtask

  task automatic pushFrame(input int d);
    word_t w;
    logic [7:0] hdr [6];
    hdr = '{8'h21, 8'h00, (d == 0) ? 8'h7F : 8'h03, 8'h22, 8'h00, (d == 0) ? 8'h07 : 8'h01};
    for (int i = 0; i < 6; i++) begin
      w.dc = 1'b0; w.data = hdr[i]; w.addr = -1;
      q.push_back(w);
    end
    for (int k = 0; k < frameLen(d); k++) begin
      w.dc = 1'b1; w.addr = k;
      if (d == 0) w.data = mem0[k];
      else        w.data = mem1[k];
      q.push_back(w);
    end
  endtask

  // One clock of the chosen instance: check what it shows now, then drive the next edge.
  task automatic applyStimulus(input int d, input logic get_in, input logic start_in, input logic rst_in);
    logic        o_empty, o_busy, o_dc, pop, nb, ne;
    logic [7:0]  o_data;
    logic [31:0] o_addr;
    word_t       w;
    @(negedge clock);
    if (d == 0) begin
      o_empty = bus0.empty; o_busy = bus0.busy; o_dc = bus0.dc;
      o_data = bus0.data; o_addr = 32'(bus0.fb_addr);
    end else begin
      o_empty = bus1.empty; o_busy = bus1.busy; o_dc = bus1.dc;
      o_data = bus1.data; o_addr = 32'(bus1.fb_addr);
    end
    if (have_exp) begin
      checkOutput("busy", 32'(o_busy), 32'(exp_busy));
      checkOutput("empty", 32'(o_empty), 32'(exp_empty));
    end
    if (prev_rst) begin
      checkOutput("rst_dc", 32'(o_dc), 32'd0);
      checkOutput("rst_data", 32'(o_data), 32'd0);
      checkOutput("rst_fb_addr", o_addr, 32'd0);
    end
    if (hold) begin
      checkOutput("hold_data", 32'(o_data), 32'(held_data));
      checkOutput("hold_dc", 32'(o_dc), 32'(held_dc));
    end
    nb = exp_busy;
    ne = exp_empty;
    hold = 1'b0;
    if (rst_in) begin
      q.delete();
      nb = (initLen(d) > 0);
      ne = 1'b1;
    end else begin
      if (prev_rst) pushInit(d);
      pop = !o_empty && get_in;
      if (pop) begin
        if (q.size() == 0) begin
          checkOutput("words_pending", 32'(q.size()), 32'd1);
        end else begin
          w = q.pop_front();
          checkOutput("data", 32'(o_data), 32'(w.data));
          checkOutput("dc", 32'(o_dc), 32'(w.dc));
          if (w.dc) pix_popped++;
          if (q.size() > 0 && q[0].dc) checkOutput("fb_addr", o_addr, 32'(q[0].addr));
        end
        if (q.size() == 0) begin
          nb = 1'b0;
          ne = 1'b1;
        end else begin
          ne = q[0].dc;
        end
      end else if (!o_empty) begin
        ne = 1'b0;
        hold = 1'b1;
        held_dc = o_dc;
        held_data = o_data;
      end else begin
        ne = (q.size() == 0);
      end
      if (start_in && !exp_busy) begin
        pushFrame(d);
        nb = 1'b1;
        ne = 1'b0;
      end
    end
    if (d == 0) begin
      bus0.get = get_in; bus0.start = start_in; reset0 = rst_in;
    end else begin
      bus1.get = get_in; bus1.start = start_in; reset1 = rst_in;
    end
    exp_busy = nb;
    exp_empty = ne;
    prev_rst = rst_in;
    have_exp = have_exp | rst_in;
  endtask

  task automatic runFrame(input int d, input int duty, input int start_at, input int max_n, input int exp_n);
    int n = 0;
    while ((q.size() > 0 || exp_busy) && n < max_n) begin
      applyStimulus(d, int'($urandom_range(0, 99)) < duty, n == start_at, 1'b0);
      n++;
    end
    checkOutput("timeout", 32'(n < max_n), 32'd1);
    if (exp_n >= 0) checkOutput("cycles", 32'(n), 32'(exp_n));
  endtask

  initial begin
    int n;
    bus0.get = 1'b0; bus0.start = 1'b0;
    bus1.get = 1'b0; bus1.start = 1'b0;
    for (int k = 0; k < 1024; k++) mem0[k] = 8'(k);
    for (int k = 0; k < 8; k++) mem1[k] = 8'(8'hA0 + k);

    // Init list back-to-back with a start request inside it that must be ignored.
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    runFrame(0, 100, 3, 100, 21);

    // Full frame at full rate, with a mid-frame start that must be ignored.
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    runFrame(0, 100, 500, 4000, 2054);

    // Random frame contents and sparse pops.
    for (int k = 0; k < 1024; k++) mem0[k] = 8'($urandom);
    applyStimulus(0, 1'b0, 1'b1, 1'b0);
    runFrame(0, 30, -1, 30000, -1);

    // Reset in the middle of the pixel stream restarts the init list.
    for (int k = 0; k < 1024; k++) mem0[k] = 8'(k);
    pix_popped = 0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (pix_popped < 300 && n < 5000) begin
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    checkOutput("pix300_timeout", 32'(n < 5000), 32'd1);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    runFrame(0, 100, -1, 100, 21);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);

    // Small geometry without an init phase.
    q.delete();
    have_exp = 1'b0;
    prev_rst = 1'b0;
    hold = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 1'b0);
    runFrame(1, 100, -1, 200, 22);
    applyStimulus(1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
